// File: rtl/sdram_client_arbiter.sv
// Arbitrates N client SDRAM request ports onto one bus-adapter port, holding the grant
// until the adapter (or the timeout) completes the transaction.
module sdram_client_arbiter #(
  parameter int NUM_CLIENTS    = 5,
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int ID_W          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CLIENTS-1:0]        cli_read,
  input  logic [NUM_CLIENTS-1:0]        cli_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_writedata,
  output logic [DATA_W-1:0]             cli_readdata,
  output logic [NUM_CLIENTS-1:0]        cli_finished,
  input  logic                          i_lock_en,
  input  logic [ID_W-1:0]               i_lock_id,
  output logic                          sdram_read,
  output logic                          sdram_write,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic [DATA_W-1:0]             sdram_writedata,
  input  logic [DATA_W-1:0]             sdram_readdata,
  input  logic                          sdram_finished,
  output logic                          o_busy,
  output logic [ID_W-1:0]               o_grant_id,
  output logic                          o_timeout,
  output logic                          o_err
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;

  state_t                  state_q;
  logic [ID_W-1:0]         grant_q, ptr_q, win;
  logic                    rd_q, wr_q, to_q, err_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q, rdata_q;
  logic [NUM_CLIENTS-1:0]  fin_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [NUM_CLIENTS-1:0]  elig, elig_hi;
  logic                    sel_rd, sel_wr;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;

  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_CLIENTS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--)
      if (v[i]) lowest_set = ID_W'(i);
  endfunction

  // Round-robin: prefer eligible clients above the pointer, else wrap to the lowest one.
  always_comb begin
    elig    = '0;
    elig_hi = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      elig[i]    = (cli_read[i] | cli_write[i]) & (!i_lock_en | (i_lock_id == ID_W'(i)));
      elig_hi[i] = elig[i] & (i > int'(ptr_q));
    end
    if ((ROUND_ROBIN != 0) && (elig_hi != '0)) win = lowest_set(elig_hi);
    else                                       win = lowest_set(elig);
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (ID_W'(i) == win) begin
        sel_rd    = cli_read[i];
        sel_wr    = cli_write[i];
        sel_addr  = cli_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = cli_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ID_W'(NUM_CLIENTS - 1);
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fin_q <= '0;
      case (state_q)
        IDLE: begin
          if (elig != '0) begin
            grant_q <= win;
            ptr_q   <= win;
            rd_q    <= sel_rd & !sel_wr;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt_q   <= '0;
            if (sel_rd & sel_wr) err_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (sdram_finished) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (rd_q) rdata_q <= sdram_readdata;
            fin_q   <= NUM_CLIENTS'(1) << grant_q;
            state_q <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            to_q    <= 1'b1;
            fin_q   <= NUM_CLIENTS'(1) << grant_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= GAP;
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdram_read      = rd_q;
  assign sdram_write     = wr_q;
  assign sdram_addr      = addr_q;
  assign sdram_writedata = wdata_q;
  assign cli_readdata    = rdata_q;
  assign cli_finished    = fin_q;
  assign o_busy          = (state_q != IDLE);
  assign o_grant_id      = grant_q;
  assign o_timeout       = to_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Bench for sdram_client_arbiter: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a transaction-level model.
module tb_sdram_client_arbiter;

  localparam int N  = 5;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int RR = 1;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    cli_read = '0, cli_write = '0;
  logic [N*AW-1:0] cli_addr = '0;
  logic [N*DW-1:0] cli_writedata = '0;
  logic [DW-1:0]   cli_readdata;
  logic [N-1:0]    cli_finished;
  logic            lock_en = 1'b0;
  logic [2:0]      lock_id = '0;
  logic            sdram_read, sdram_write;
  logic [AW-1:0]   sdram_addr;
  logic [DW-1:0]   sdram_writedata;
  logic [DW-1:0]   sdram_readdata = '0;
  logic            sdram_finished = 1'b0;
  logic            o_busy, o_timeout, o_err;
  logic [2:0]      o_grant_id;

  sdram_client_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(RR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .cli_read(cli_read), .cli_write(cli_write), .cli_addr(cli_addr),
    .cli_writedata(cli_writedata), .cli_readdata(cli_readdata), .cli_finished(cli_finished),
    .i_lock_en(lock_en), .i_lock_id(lock_id),
    .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
    .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
    .sdram_finished(sdram_finished),
    .o_busy(o_busy), .o_grant_id(o_grant_id), .o_timeout(o_timeout), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic          e_read = 0, e_write = 0, e_busy = 0, e_to = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;
  logic [N-1:0]  e_fin = '0;
  logic [2:0]    e_gid = '0;
  int m_ptr = N - 1, m_act = 0, m_el = 0, m_post = 0, m_gid = 0, m_w = 0, m_c = 0;
  bit m_wr = 0;

  function automatic bit eligible(input int c);
    return (cli_read[c] | cli_write[c]) && (!lock_en || int'(lock_id) == c);
  endfunction

  task automatic complete();
    e_read = 0; e_write = 0;
    e_fin  = N'(1 << m_gid);
    m_post = 2;
    m_act  = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_read = 0; e_write = 0; e_busy = 0; e_to = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_fin = '0; e_gid = '0;
      m_ptr = N - 1; m_act = 0; m_el = 0; m_post = 0;
    end else begin
      e_fin = '0;
      if (m_post > 0) begin
        m_post--;
        if (m_post == 0) e_busy = 0;
      end else if (m_act != 0) begin
        if (sdram_finished) begin
          if (!m_wr) e_rdata = sdram_readdata;
          complete();
        end else begin
          m_el++;
          if (TO > 0 && m_el == TO) begin
            e_rdata = '0;
            e_to    = 1;
            complete();
          end
        end
      end else begin
        m_w = -1;
        for (int k = 1; k <= N; k++) begin
          m_c = RR ? (m_ptr + k) % N : k - 1;
          if (m_w < 0 && eligible(m_c)) m_w = m_c;
        end
        if (m_w >= 0) begin
          m_ptr   = m_w;
          m_gid   = m_w;
          m_act   = 1;
          m_el    = 0;
          m_wr    = cli_write[m_w];
          e_busy  = 1;
          e_gid   = 3'(m_w);
          e_read  = !cli_write[m_w];
          e_write = cli_write[m_w];
          e_addr  = cli_addr[m_w*AW +: AW];
          e_wdata = cli_writedata[m_w*DW +: DW];
          if (cli_read[m_w] && cli_write[m_w]) e_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sdram_read",      64'(sdram_read),      64'(e_read));
      chk("sdram_write",     64'(sdram_write),     64'(e_write));
      chk("sdram_addr",      64'(sdram_addr),      64'(e_addr));
      chk("sdram_writedata", 64'(sdram_writedata), 64'(e_wdata));
      chk("cli_readdata",    64'(cli_readdata),    64'(e_rdata));
      chk("cli_finished",    64'(cli_finished),    64'(e_fin));
      chk("o_busy",          64'(o_busy),          64'(e_busy));
      chk("o_grant_id",      64'(o_grant_id),      64'(e_gid));
      chk("o_timeout",       64'(o_timeout),       64'(e_to));
      chk("o_err",           64'(o_err),           64'(e_err));
    end
  end

  // ---------------- SDRAM adapter stand-in ----------------
  int          ad_cnt = 0, ad_delay = 0, ad_fixed = 3;
  bit          ad_rand = 0, ad_spur = 0;
  logic [31:0] ad_data = 32'hDEADBEEF;

  always @(negedge clk) begin
    if (sdram_read | sdram_write) begin
      if (ad_cnt == 0) ad_delay = ad_rand ? int'($urandom_range(1, 10)) : ad_fixed;
      ad_cnt++;
      sdram_finished = (ad_cnt == ad_delay);
      sdram_readdata = ad_rand ? $urandom : ad_data;
    end else begin
      ad_cnt = 0;
      sdram_finished = ad_spur && ($urandom_range(0, 3) == 0);
      sdram_readdata = $urandom;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", 64'({sdram_read, sdram_write, o_busy, o_timeout, o_err, cli_finished, o_grant_id}), 64'd0);
    chk("reset_data", 64'({sdram_addr, cli_readdata}), 64'd0);
    #2 rst = 1'b0;
  endtask

  task automatic run_txn(output logic [N-1:0] fin, output int rdc, output int wrc,
                         output logic [31:0] wd0, output logic rd0, output logic wr0,
                         output logic [AW-1:0] a0);
    bit seen = 0;
    fin = '0; rdc = 0; wrc = 0; wd0 = '0; rd0 = 0; wr0 = 0; a0 = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((sdram_read | sdram_write) && !seen) begin
        seen = 1; rd0 = sdram_read; wr0 = sdram_write; wd0 = sdram_writedata; a0 = sdram_addr;
      end
      if (sdram_read)  rdc++;
      if (sdram_write) wrc++;
      if (cli_finished != '0) begin
        fin = cli_finished;
        return;
      end
    end
    errors++;
    checks++;
    $display("FAIL txn_wait: no cli_finished within 60 cycles (t=%0t)", $time);
  endtask

  logic [N-1:0]  fin;
  int            rdc, wrc, nfin;
  logic [31:0]   wd0;
  logic          rd0, wr0;
  logic [AW-1:0] a0;
  logic [N-1:0]  rr_exp [6] = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
  int            op;

  initial begin
    do_reset();
    cmp_en = 1'b1;

    // single read, then a timed-out read replacing the read data with 0
    @(negedge clk);
    cli_read[2] = 1'b1;
    cli_addr[2*AW +: AW] = 23'h000100;
    run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
    chk("rd_finished", 64'(fin), 64'(5'b00100));
    chk("rd_strobe_cycles", 64'(rdc), 64'd3);
    chk("rd_addr", 64'(a0), 64'h100);
    chk("rd_data", 64'(cli_readdata), 64'hDEADBEEF);
    chk("rd_grant", 64'(o_grant_id), 64'd2);
    cli_read[2] = 1'b0;
    ad_fixed = 0;
    @(negedge clk);
    cli_read[1] = 1'b1;
    run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
    chk("to_finished", 64'(fin), 64'(5'b00010));
    chk("to_strobe_cycles", 64'(rdc), 64'd8);
    chk("to_flag", 64'(o_timeout), 64'd1);
    chk("to_rdata", 64'(cli_readdata), 64'd0);
    cli_read[1] = 1'b0;
    ad_fixed = 3;

    // round-robin among continuously requesting clients 0,1,3
    do_reset();
    cli_read = 5'b01011;
    for (int n = 0; n < 6; n++) begin
      run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
      chk("rr_order", 64'(fin), 64'(rr_exp[n]));
    end
    cli_read = '0;

    // exclusive lock on client 4
    do_reset();
    lock_en = 1'b1;
    lock_id = 3'd4;
    cli_read = 5'b10001;
    run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
    chk("lock_served", 64'(fin), 64'(5'b10000));
    cli_read[4] = 1'b0;
    repeat (6) @(negedge clk);
    chk("lock_blocks", 64'({o_busy, sdram_read}), 64'd0);
    lock_en = 1'b0;
    run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
    chk("unlock_served", 64'(fin), 64'(5'b00001));
    cli_read[0] = 1'b0;

    // read+write conflict is issued as a write and flagged
    @(negedge clk);
    ad_fixed = 2;
    cli_read[1] = 1'b1;
    cli_write[1] = 1'b1;
    cli_writedata[1*DW +: DW] = 32'h12345678;
    run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
    chk("cf_strobes", 64'({rd0, wr0}), 64'(2'b01));
    chk("cf_wdata", 64'(wd0), 64'h12345678);
    chk("cf_err", 64'(o_err), 64'd1);
    chk("cf_finished", 64'(fin), 64'(5'b00010));
    chk("wr_keeps_rdata", 64'(cli_readdata), 64'hDEADBEEF);
    cli_read[1] = 1'b0;
    cli_write[1] = 1'b0;

    // asynchronous reset in the middle of a transaction
    @(negedge clk);
    ad_fixed = 0;
    cli_read = 5'b01001;
    for (int i = 0; i < 10 && !sdram_read; i++) @(negedge clk);
    chk("pre_rst_strobe", 64'(sdram_read), 64'd1);
    chk("pre_rst_grant", 64'(o_grant_id), 64'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 64'({sdram_read, sdram_write, o_busy, o_timeout, o_err, cli_finished, o_grant_id}), 64'd0);
    chk("async_rst_data", 64'({sdram_addr, sdram_writedata}), 64'd0);
    @(negedge clk);
    ad_fixed = 2;
    #2 rst = 1'b0;
    run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
    chk("post_rst_first", 64'(fin), 64'(5'b00001));
    cli_read[0] = 1'b0;
    run_txn(fin, rdc, wrc, wd0, rd0, wr0, a0);
    chk("post_rst_second", 64'(fin), 64'(5'b01000));
    cli_read = '0;

    // randomized traffic, checked by the model every cycle
    do_reset();
    ad_rand = 1;
    ad_spur = 1;
    nfin = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cli_finished != '0) nfin++;
      for (int i = 0; i < N; i++) begin
        if (cli_finished[i]) begin
          cli_read[i] = 1'b0;
          cli_write[i] = 1'b0;
        end else if (!(cli_read[i] | cli_write[i])) begin
          if ($urandom_range(0, 3) == 0) begin
            op = int'($urandom_range(0, 9));
            cli_read[i]  = (op < 5) || (op == 9);
            cli_write[i] = (op >= 5);
            cli_addr[i*AW +: AW] = AW'($urandom);
            cli_writedata[i*DW +: DW] = $urandom;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          cli_read[i] = 1'b0;
          cli_write[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
          cli_addr[i*AW +: AW] = AW'($urandom);
          cli_writedata[i*DW +: DW] = $urandom;
        end
      end
      if ($urandom_range(0, 19) == 0) begin
        lock_en = ($urandom_range(0, 2) == 0);
        lock_id = 3'($urandom_range(0, 7));
      end
    end
    cli_read = '0;
    cli_write = '0;
    lock_en = 1'b0;
    ad_spur = 0;
    repeat (20) @(negedge clk);
    chk("rnd_activity", 64'(nfin > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
